bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Parametrised sequential binary-to-8421-BCD converter using shift-and-add-3 (double dabble).
- Replaces the fixed 16-bit lookup-and-add converter with a generic one:
  - any input width and digit count
  - valid/ready handshake on input and output
  - overflow detection
  - optional signed mode
- Sits between datapath counters/ALU results and display/UART formatting logic.

Parameters:
- BIN_W, 16: binary input width, 1..64.
- DIG, 5: number of BCD output digits, 1..20. Values below ceil(BIN_W*0.30103) are legal but can overflow.

Ports:
- Sys_CLK  in  1  system clock, rising-edge.
- Sys_RST  in  1  synchronous reset, active-high.
- In_Valid  in  1  Data_Bin valid.
- In_Ready  out  1  converter idle, can accept input.
- Data_Bin  in  BIN_W  binary operand.
- Out_Valid  out  1  result valid.
- Out_Ready  in  1  downstream accepts result.
- Data_BCD  out  4*DIG  packed BCD result, digit 0 in [3:0].
- Ovf  out  1  result exceeded DIG digits; Data_BCD holds the truncated low digits.
- Sign  out  1  sign of result (SIGNED_EN only; otherwise constant 0).

Behaviour:
- Reset:
  - One clock; Sys_RST is synchronous and active-high, sampled on the rising edge of Sys_CLK, and overrides all other inputs.
  - After reset: state=IDLE, In_Ready=1, Out_Valid=0, Data_BCD=0, Ovf=0, Sign=0, internal shift/count registers=0.
- State IDLE:
  - In_Ready=1.
  - On In_Valid&&In_Ready at edge T: load bin shift register with Data_Bin, clear BCD register and overflow sticky, set count=BIN_W, go CONV.
- State CONV:
  - In_Ready=0, Out_Valid=0.
  - Each edge, one iteration:
    - every 4-bit digit >=5 gets +3 (all digits corrected in parallel from pre-correction values);
    - then {bcd,bin} shifts left 1.
  - The bit shifted out of the top of the BCD register ORs into the Ovf sticky. A corrected top digit >=8 therefore sets Ovf.
  - count decrements. After the iteration that takes count to 0 (edge T+BIN_W), go DONE.
- State DONE:
  - Out_Valid=1; Data_BCD and Ovf stable and held until Out_Valid&&Out_Ready.
  - On handshake edge: return to IDLE, Out_Valid=0. Data_BCD keeps its last value (not cleared).
- Latency:
  - Out_Valid rises BIN_W cycles after the accept edge.
  - Throughput: one conversion per BIN_W+2 cycles when Out_Ready is held high (accept, BIN_W iterations, output handshake, re-enter IDLE).
- Boundary conditions:
  - In_Valid while busy: ignored, no state change; upstream must hold.
  - Out_Ready high before Out_Valid: no effect.
  - Reset mid-CONV or in DONE: conversion aborted, outputs to reset values next cycle.
  - Data_Bin=0 gives all-zero BCD, Ovf=0.
  - Data_Bin=all-ones gives exact decimal of 2^BIN_W-1 when DIG is sufficient.
  - Data_Bin is only sampled at the accept edge; later changes have no effect.
- Width rules:
  - The internal BCD register is exactly 4*DIG bits; no hidden extra digit.
  - count register width is clog2(BIN_W+1).

Optional Feature:
- Macro: BIN_TO_BCD_SIGNED_EN.
- Defined:
  - Data_Bin is two's complement. At accept, Sign is captured from Data_Bin[BIN_W-1] and the magnitude is loaded into the shift register.
  - Magnitude is computed at BIN_W bits, unsigned, so the most negative value converts to 2^(BIN_W-1) without overflow of the magnitude path.
  - Sign is valid with Out_Valid and held like Data_BCD.
- Not defined:
  - Data_Bin is unsigned and Sign is tied 0.
  - No negate logic is synthesised.

Test Plan:
1. BIN_W=16, DIG=5, Data_Bin=16'hFFFF, Out_Ready=1 -> Out_Valid 16 cycles after accept, Data_BCD=20'h65535, Ovf=0.
2. Data_Bin=0 then Data_Bin=16'd9 back-to-back -> Data_BCD=20'h00000, then 20'h00009. In_Ready low throughout each CONV, second accept no earlier than the cycle after the first output handshake.
3. Data_Bin=16'd1234, Out_Ready=0 for 10 cycles after Out_Valid -> Data_BCD=20'h01234 held stable, Out_Valid held. In_Valid pulses during the wait are ignored.
4. Sys_RST asserted 5 cycles into a conversion of 16'd4321 -> next cycle Out_Valid=0, In_Ready=1, Data_BCD=0. A fresh conversion of 16'd77 then gives 20'h00077.
5. BIN_W=16, DIG=3, Data_Bin=16'd1000 -> Data_BCD=12'h000, Ovf=1. Data_Bin=16'd999 -> 12'h999, Ovf=0.
6. BIN_TO_BCD_SIGNED_EN, BIN_W=16, DIG=5:
   - Data_Bin=16'h8000 -> Sign=1, Data_BCD=20'h32768.
   - 16'hFFFF -> Sign=1, 20'h00001.
   - 16'h7FFF -> Sign=0, 20'h32767.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter using shift-and-add-3
// (double dabble). It handles one input bit per clock and uses valid/ready
// handshakes on both the input and the output.
// Optional feature: define BIN_TO_BCD_SIGNED_EN to treat Data_Bin as two's
// complement. The magnitude is converted and the sign is reported on Sign.
module bin_to_bcd_seq #(
    parameter int BIN_W = 16,
    parameter int DIG   = 5
) (
    input  logic             Sys_CLK,
    input  logic             Sys_RST,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [BIN_W-1:0] Data_Bin,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [4*DIG-1:0] Data_BCD,
    output logic             Ovf,
    output logic             Sign
);
    localparam int BCD_W = 4 * DIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;
    logic             sign_q;

    logic [BCD_W-1:0] bcd_adj;
    logic [BIN_W-1:0] load_val;
    logic             load_sign;

`ifdef BIN_TO_BCD_SIGNED_EN
    // Two's-complement magnitude at full width, so the most negative input becomes 2^(BIN_W-1)
    always_comb begin
        load_sign = Data_Bin[BIN_W-1];
        load_val  = load_sign ? (~Data_Bin + BIN_W'(1)) : Data_Bin;
    end
`else
    // Unsigned operand: load it as-is, sign is always positive
    always_comb begin
        load_sign = 1'b0;
        load_val  = Data_Bin;
    end
`endif

    // Add-3 correction on every digit in parallel, using the pre-correction values
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIG; i++) begin
            bcd_adj[4*i +: 4] = (bcd_sr[4*i +: 4] >= 4'd5) ? bcd_sr[4*i +: 4] + 4'd3
                                                           : bcd_sr[4*i +: 4];
        end
    end

    // Control FSM and datapath; handshake outputs are registered with the state
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            state     <= IDLE;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        bin_sr   <= load_val;
                        bcd_sr   <= '0;
                        ovf_q    <= 1'b0;
                        sign_q   <= load_sign;
                        cnt      <= CNT_W'(BIN_W);
                        In_Ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    // Shift {bcd,bin} left. A bit leaving the top digit means the value was truncated.
                    {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
                    ovf_q            <= ovf_q | bcd_adj[BCD_W-1];
                    cnt              <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        Out_Valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result stays held until downstream takes it. The BCD register is not cleared here.
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        In_Ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Data_BCD = bcd_sr;
    assign Ovf      = ovf_q;
    assign Sign     = sign_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq. One instance is built with DIG=5 and one with DIG=3 to exercise overflow.
module tb_bin_to_bcd_seq;
    localparam int BIN_W = 16;

    logic        Sys_CLK = 1'b0;
    logic        Sys_RST;
    logic        In_Valid, In_Ready, Out_Valid, Out_Ready, Ovf, Sign;
    logic [15:0] Data_Bin;
    logic [19:0] Data_BCD;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf, s_sign;
    logic [15:0] s_data_bin;
    logic [11:0] s_data_bcd;

    int checks = 0;
    int errors = 0;

    always #5 Sys_CLK = ~Sys_CLK;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIG(5)) u_dut (
        .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .Data_Bin(Data_Bin),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Data_BCD(Data_BCD),
        .Ovf(Ovf), .Sign(Sign)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIG(3)) u_dut3 (
        .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST),
        .In_Valid(s_in_valid), .In_Ready(s_in_ready), .Data_Bin(s_data_bin),
        .Out_Valid(s_out_valid), .Out_Ready(s_out_ready), .Data_BCD(s_data_bcd),
        .Ovf(s_ovf), .Sign(s_sign)
    );

    task automatic tick();
        @(posedge Sys_CLK);
        #1;
    endtask

    // Accept d on the wide instance and wait (bounded) for Out_Valid. Out_Ready is left at 0.
    task automatic run_conv(input logic [15:0] d, output logic ok);
        Out_Ready = 1'b0;
        Data_Bin  = d;
        In_Valid  = 1'b1;
        tick();
        In_Valid  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = Out_Valid;
        end
    endtask

    // Same as run_conv, but for the DIG=3 instance
    task automatic run_conv3(input logic [15:0] d, output logic ok);
        s_out_ready = 1'b0;
        s_data_bin  = d;
        s_in_valid  = 1'b1;
        tick();
        s_in_valid  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = s_out_valid;
        end
    endtask

    task automatic test_reset();
        Sys_RST = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0; Data_Bin = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_data_bin = '0;
        tick(); tick();
        Sys_RST = 1'b0;
        checks++;
        if ({In_Ready, Out_Valid, Data_BCD, Ovf, Sign} !== {1'b1, 1'b0, 20'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b bcd=%h ovf=%b sign=%b, required 1 0 00000 0 0",
                     In_Ready, Out_Valid, Data_BCD, Ovf, Sign);
        end
        checks++;
        if ({s_in_ready, s_out_valid, s_data_bcd, s_ovf} !== {1'b1, 1'b0, 12'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dig3: rdy=%b vld=%b bcd=%h ovf=%b", s_in_ready, s_out_valid, s_data_bcd, s_ovf);
        end
    endtask

    // All-ones input with Out_Ready held high before the result appears; checks exact latency
    task automatic test_max();
        logic early;
        logic [19:0] exp_bcd;
        logic        exp_sign;
`ifdef BIN_TO_BCD_SIGNED_EN
        exp_bcd = 20'h00001; exp_sign = 1'b1;
`else
        exp_bcd = 20'h65535; exp_sign = 1'b0;
`endif
        early = 1'b0;
        Out_Ready = 1'b1; Data_Bin = 16'hFFFF; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (Out_Valid !== 1'b0 || In_Ready !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL max_busy: Out_Valid or In_Ready high during conversion, required both low");
        end
        tick();
        checks++;
        if ({Out_Valid, Data_BCD, Ovf, Sign} !== {1'b1, exp_bcd, 1'b0, exp_sign}) begin
            errors++;
            $display("FAIL max_result: vld=%b bcd=%h ovf=%b sign=%b, required 1 %h 0 %b",
                     Out_Valid, Data_BCD, Ovf, Sign, exp_bcd, exp_sign);
        end
        tick();
        checks++;
        if ({Out_Valid, In_Ready, Data_BCD} !== {1'b0, 1'b1, exp_bcd}) begin
            errors++;
            $display("FAIL max_handshake: vld=%b rdy=%b bcd=%h, required 0 1 %h", Out_Valid, In_Ready, Data_BCD, exp_bcd);
        end
        Out_Ready = 1'b0;
    endtask

    // 0 then 9 with In_Valid held continuously. Data_Bin changes right after the first accept.
    task automatic test_back_to_back();
        logic busy_bad;
        busy_bad = 1'b0;
        Out_Ready = 1'b1; Data_Bin = 16'd0; In_Valid = 1'b1;
        tick();
        Data_Bin = 16'd9;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (In_Ready !== 1'b0) busy_bad = 1'b1;
        end
        checks++;
        if ({Out_Valid, Data_BCD, Ovf} !== {1'b1, 20'h00000, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first: vld=%b bcd=%h ovf=%b, required 1 00000 0", Out_Valid, Data_BCD, Ovf);
        end
        tick();
        checks++;
        if ({Out_Valid, In_Ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_handshake: vld=%b rdy=%b, required 0 1", Out_Valid, In_Ready);
        end
        tick();
        In_Valid = 1'b0;
        checks++;
        if (In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: rdy=%b, required 0", In_Ready);
        end
        for (int i = 1; i <= 16; i++) begin
            if (In_Ready !== 1'b0) busy_bad = 1'b1;
            tick();
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL b2b_busy: In_Ready high during a conversion, required low");
        end
        checks++;
        if ({Out_Valid, Data_BCD} !== {1'b1, 20'h00009}) begin
            errors++;
            $display("FAIL b2b_second: vld=%b bcd=%h, required 1 00009", Out_Valid, Data_BCD);
        end
        tick();
        Out_Ready = 1'b0;
    endtask

    // Output backpressure: the result must hold, and In_Valid pulses must be ignored
    task automatic test_hold();
        logic ok, hold_bad;
        hold_bad = 1'b0;
        run_conv(16'd1234, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_timeout: Out_Valid=%b, required 1 within 40 cycles", Out_Valid);
        end
        for (int i = 0; i < 10; i++) begin
            In_Valid = i[0];
            Data_Bin = 16'd5555;
            tick();
            if (Out_Valid !== 1'b1 || Data_BCD !== 20'h01234 || In_Ready !== 1'b0) hold_bad = 1'b1;
        end
        In_Valid = 1'b0;
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL hold_stable: vld=%b bcd=%h rdy=%b, required 1 01234 0", Out_Valid, Data_BCD, In_Ready);
        end
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        checks++;
        if ({Out_Valid, In_Ready, Data_BCD} !== {1'b0, 1'b1, 20'h01234}) begin
            errors++;
            $display("FAIL hold_release: vld=%b rdy=%b bcd=%h, required 0 1 01234", Out_Valid, In_Ready, Data_BCD);
        end
    endtask

    // Reset in the middle of a conversion and while in DONE
    task automatic test_reset_mid();
        logic ok;
        Data_Bin = 16'd4321; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        repeat (5) tick();
        Sys_RST = 1'b1;
        tick();
        Sys_RST = 1'b0;
        checks++;
        if ({Out_Valid, In_Ready, Data_BCD, Ovf} !== {1'b0, 1'b1, 20'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: vld=%b rdy=%b bcd=%h ovf=%b, required 0 1 00000 0", Out_Valid, In_Ready, Data_BCD, Ovf);
        end
        run_conv(16'd77, ok);
        checks++;
        if (!ok || Data_BCD !== 20'h00077) begin
            errors++;
            $display("FAIL rst_fresh: vld=%b bcd=%h, required 1 00077", Out_Valid, Data_BCD);
        end
        Sys_RST = 1'b1;
        tick();
        Sys_RST = 1'b0;
        checks++;
        if ({Out_Valid, In_Ready, Data_BCD} !== {1'b0, 1'b1, 20'h0}) begin
            errors++;
            $display("FAIL rst_done: vld=%b rdy=%b bcd=%h, required 0 1 00000", Out_Valid, In_Ready, Data_BCD);
        end
    endtask

    // Overflow on the 3-digit instance: 1000 and 65535 do not fit in 3 digits, but 999 does
    task automatic test_ovf();
        logic ok;
        run_conv3(16'd1000, ok);
        checks++;
        if (!ok || {s_data_bcd, s_ovf} !== {12'h000, 1'b1}) begin
            errors++;
            $display("FAIL ovf_1000: vld=%b bcd=%h ovf=%b, required 1 000 1", s_out_valid, s_data_bcd, s_ovf);
        end
        s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
        run_conv3(16'd999, ok);
        checks++;
        if (!ok || {s_data_bcd, s_ovf} !== {12'h999, 1'b0}) begin
            errors++;
            $display("FAIL ovf_999: vld=%b bcd=%h ovf=%b, required 1 999 0", s_out_valid, s_data_bcd, s_ovf);
        end
        s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
`ifndef BIN_TO_BCD_SIGNED_EN
        run_conv3(16'hFFFF, ok);
        checks++;
        if (!ok || {s_data_bcd, s_ovf} !== {12'h535, 1'b1}) begin
            errors++;
            $display("FAIL ovf_ffff: vld=%b bcd=%h ovf=%b, required 1 535 1", s_out_valid, s_data_bcd, s_ovf);
        end
        s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
`endif
    endtask

    // Sign handling. In unsigned builds, 8000/7FFF convert as plain values and Sign stays 0.
    task automatic test_signed();
        logic        ok;
        logic [15:0] din [3];
        logic [19:0] ebcd [3];
        logic        esgn [3];
        din[0] = 16'h8000; din[1] = 16'h7FFF; din[2] = 16'd42;
`ifdef BIN_TO_BCD_SIGNED_EN
        ebcd[0] = 20'h32768; esgn[0] = 1'b1;
`else
        ebcd[0] = 20'h32768; esgn[0] = 1'b0;
`endif
        ebcd[1] = 20'h32767; esgn[1] = 1'b0;
        ebcd[2] = 20'h00042; esgn[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_conv(din[k], ok);
            checks++;
            if (!ok || {Data_BCD, Sign, Ovf} !== {ebcd[k], esgn[k], 1'b0}) begin
                errors++;
                $display("FAIL signed_%h: vld=%b bcd=%h sign=%b ovf=%b, required 1 %h %b 0",
                         din[k], Out_Valid, Data_BCD, Sign, Ovf, ebcd[k], esgn[k]);
            end
            Out_Ready = 1'b1; tick(); Out_Ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_ovf();
        test_signed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
